// File: rtl/cello_sweep_pkg.sv
// Shared types and sizes for the 3-input truth-table sweeper.
package cello_sweep_pkg;
  localparam int NUM_VECTORS = 8;
  localparam int VEC_W       = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } sweep_state_e;
endpackage

// File: rtl/sweep_settle_counter.sv
// Settle-window counter: counts 0..SETTLE_CYCLES-1 while enabled, wrapping at terminal count.
module sweep_settle_counter #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = 8'd0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= 8'd0;
    else     cnt_q <= cnt_d;
  end

  assign tc_o = (cnt_q == LAST);
endmodule

// File: rtl/truth_table_sweeper.sv
// Walks all 8 input vectors of a 3-input circuit, samples its output after a settle
// window per vector and compares the assembled truth-table code to a captured expectation.
module truth_table_sweeper
  import cello_sweep_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NUM_VECTORS-1:0] expected,
  input  logic                   dut_out,
  output logic [VEC_W-1:0]       dut_in,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_VECTORS-1:0] table_q,
  output logic                   match,
  output logic [NUM_VECTORS-1:0] fail_mask
);
  localparam logic [VEC_W-1:0] LAST_IDX = VEC_W'(NUM_VECTORS - 1);

  // start is a level request sampled only in IDLE (no handshake back, no queueing);
  // abort is sampled every SWEEP cycle and outranks the final sample.
  sweep_state_e           state_q, state_d;
  logic [VEC_W-1:0]       idx_q, idx_d;
  logic [NUM_VECTORS-1:0] shadow_q, shadow_d;
  logic [NUM_VECTORS-1:0] exp_q, exp_d;
  logic [NUM_VECTORS-1:0] table_d;
  logic [NUM_VECTORS-1:0] fail_q, fail_d;
  logic                   match_q, match_d;
  logic                   done_q, done_d;
  logic                   tc;

  sweep_settle_counter #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk  (clk),
    .rst  (rst),
    .clr_i(state_q == IDLE || abort),
    .en_i (state_q == SWEEP),
    .tc_o (tc)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    exp_d    = exp_q;
    table_d  = table_q;
    fail_d   = fail_q;
    match_d  = match_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d  = SWEEP;
          idx_d    = '0;
          shadow_d = '0;
          exp_d    = expected;
        end
      end
      SWEEP: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (tc) begin
          shadow_d[idx_q] = dut_out;
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            table_d = shadow_d;
            fail_d  = shadow_d ^ exp_q;
            match_d = (shadow_d == exp_q);
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + VEC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      exp_q    <= '0;
      table_q  <= '0;
      fail_q   <= '0;
      match_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      exp_q    <= exp_d;
      table_q  <= table_d;
      fail_q   <= fail_d;
      match_q  <= match_d;
      done_q   <= done_d;
    end
  end

  // idx is held at 0 outside a sweep, so it doubles as the circuit input bus.
  assign dut_in    = idx_q;
  assign busy      = (state_q == SWEEP);
  assign done      = done_q;
  assign match     = match_q;
  assign fail_mask = fail_q;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: directed and random sweeps against a behavioural gate model.
module tb_truth_table_sweeper;
  localparam int S4 = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // S=4 instance
  logic       start = 1'b0, abort = 1'b0;
  logic [7:0] expected = 8'h00, model = 8'h00;
  logic       dut_out;
  logic [2:0] dut_in;
  logic       busy, done, match;
  logic [7:0] table_q, fail_mask;

  // S=1 instance
  logic       start1 = 1'b0, abort1 = 1'b0;
  logic [7:0] expected1 = 8'h00, model1 = 8'h00;
  logic       dut_out1;
  logic [2:0] dut_in1;
  logic       busy1, done1, match1;
  logic [7:0] table1, fail_mask1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // last completed result expected on the S=4 instance
  logic [7:0] last_table = 8'h00, last_fail = 8'h00;
  logic       last_match = 1'b0;

  always #5 clk = ~clk;

  // behavioural gate: out = bit {in1,in2,in3} of the model code
  assign dut_out  = model[dut_in];
  assign dut_out1 = model1[dut_in1];

  truth_table_sweeper #(.SETTLE_CYCLES(S4)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .expected(expected),
    .dut_out(dut_out), .dut_in(dut_in), .busy(busy), .done(done),
    .table_q(table_q), .match(match), .fail_mask(fail_mask)
  );

  truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .expected(expected1),
    .dut_out(dut_out1), .dut_in(dut_in1), .busy(busy1), .done(done1),
    .table_q(table1), .match(match1), .fail_mask(fail_mask1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_result(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_dut_in"}, dut_in, 0);
    chk({tag, "_table"}, table_q, last_table);
    chk({tag, "_match"}, match, last_match);
    chk({tag, "_fail"}, fail_mask, last_fail);
  endtask

  // One sweep on the S=4 instance. abort_at / pulse_* are edge numbers after the
  // accepting edge (0 = never). expected is scrambled mid-sweep to prove it was captured.
  task automatic sweep(input logic [7:0] m, input logic [7:0] e, input int abort_at,
                       input int pulse_a, input int pulse_b);
    model = m;
    expected = e;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("accept_busy", busy, 1);
    chk("accept_dut_in", dut_in, 0);
    chk("accept_done", done, 0);
    for (int t = 1; t <= 8 * S4; t++) begin
      if (t == abort_at) abort = 1'b1;
      if (t == pulse_a || t == pulse_b) start = 1'b1;
      if (t == 3) expected = 8'($urandom);
      step();
      abort = 1'b0;
      start = 1'b0;
      if (t == abort_at) begin
        chk("abort_done", done, 0);
        chk_idle_result("abort");
        step();
        chk("abort_no_late_done", done, 0);
        chk_idle_result("abort_after");
        return;
      end
      if (t < 8 * S4) begin
        chk("sweep_dut_in", dut_in, t / S4);
        chk("sweep_busy", busy, 1);
        chk("sweep_done", done, 0);
      end
    end
    last_table = m;
    last_match = (m == e);
    last_fail  = m ^ e;
    chk("done_pulse", done, 1);
    chk_idle_result("done");
    step();
    chk("done_one_cycle", done, 0);
    chk_idle_result("post_done");
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_dut_in", dut_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_table", table_q, 0);
    chk("rst_match", match, 0);
    chk("rst_fail", fail_mask, 0);
    step();
    step();
    rst = 1'b0;
    step();

    // abort in IDLE blocks start
    abort = 1'b1;
    start = 1'b1;
    step();
    abort = 1'b0;
    start = 1'b0;
    chk("idle_abort_busy", busy, 0);

    sweep(8'h81, 8'h81, 0, 0, 0);
    sweep(8'h81, 8'h80, 0, 0, 0);
    sweep(8'h81, 8'h81, 0, 0, 0);
    sweep(8'hFE, 8'hFE, 10, 0, 0);
    sweep(8'h81, 8'h81, 0, 5, 20);
    sweep(8'h3C, 8'h5A, 8 * S4, 0, 0);

    // reset mid-sweep
    model = 8'hA5;
    expected = 8'hA5;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int t = 1; t <= 12; t++) step();
    #2 rst = 1'b1;
    #1;
    chk("midrst_dut_in", dut_in, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_table", table_q, 0);
    chk("midrst_match", match, 0);
    chk("midrst_fail", fail_mask, 0);
    step();
    rst = 1'b0;
    last_table = 8'h00;
    last_match = 1'b0;
    last_fail  = 8'h00;
    for (int t = 0; t < 4; t++) begin
      step();
      chk("midrst_no_done", done, 0);
    end
    sweep(8'h6B, 8'h6B, 0, 0, 0);

    // random sweeps, some aborted
    for (int n = 0; n < 10; n++) begin
      logic [7:0] m, e;
      int ab;
      m  = 8'($urandom);
      e  = ($urandom_range(0, 1) == 1) ? m : 8'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 8 * S4) : 0;
      sweep(m, e, ab, $urandom_range(0, 8 * S4), 0);
      for (int k = $urandom_range(0, 3); k > 0; k--) step();
    end

    // S=1: restart requested in the done cycle
    model1 = 8'h81;
    expected1 = 8'h81;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("s1_accept_busy", busy1, 1);
    for (int t = 1; t <= 7; t++) begin
      step();
      chk("s1_dut_in", dut_in1, t);
      chk("s1_done", done1, 0);
    end
    step();
    chk("s1_done_pulse", done1, 1);
    chk("s1_table", table1, 8'h81);
    chk("s1_match", match1, 1);
    chk("s1_fail", fail_mask1, 8'h00);
    model1 = 8'h17;
    expected1 = 8'h16;
    start1 = 1'b1;
    step();
    start1 = 1'b0;
    chk("s1_restart_busy", busy1, 1);
    chk("s1_restart_dut_in", dut_in1, 0);
    chk("s1_restart_done", done1, 0);
    for (int t = 1; t <= 7; t++) begin
      step();
      chk("s1_second_done_early", done1, 0);
    end
    step();
    chk("s1_second_done", done1, 1);
    chk("s1_second_table", table1, 8'h17);
    chk("s1_second_match", match1, 0);
    chk("s1_second_fail", fail_mask1, 8'h01);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
